// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - winner selection; DMEM_ARB_RR_EN selects round-robin, otherwise fixed priority
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

`ifdef DMEM_ARB_RR_EN
    // Contention goes to the port that did not win last; a lone requester always wins
    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = PORT_DMA;
        end
    end
`else
    // CPU port wins whenever it requests; last is tracked by the caller but ignored here
    logic unused_pick;
    assign unused_pick = &{1'b0, last, req1};

    always_comb begin
        winner = PORT_CPU;
        if (!req0) begin
            winner = PORT_DMA;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter for the single-port data memory (DMEM_ARB_RR_EN: round-robin)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    state_t state_next;

    logic owner;
    logic last;
    logic is_read;
    logic winner;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    dmem_arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (winner)
    );

    // Owner's request fields, steered once so the FSM only sees one port
    assign sel_we    = (owner == PORT_DMA) ? we1    : we0;
    assign sel_addr  = (owner == PORT_DMA) ? addr1  : addr0;
    assign sel_wdata = (owner == PORT_DMA) ? wdata1 : wdata0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus all handshake and memory-side outputs; mem_* are 0 outside ACCESS
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rvalid0    = 1'b0;
        rvalid1    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
                gnt0       = (owner == PORT_CPU);
                gnt1       = (owner == PORT_DMA);
                mem_read   = ~sel_we;
                mem_write  = sel_we;
                mem_addr   = sel_addr;
                mem_wdata  = sel_wdata;
            end
            RESP: begin
                state_next = IDLE;
                rvalid0    = is_read && (owner == PORT_CPU);
                rvalid1    = is_read && (owner == PORT_DMA);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Arbitration bookkeeping and read-data capture at the edge that closes ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            owner   <= PORT_CPU;
            last    <= PORT_DMA;
            is_read <= 1'b0;
            rdata   <= '0;
        end else begin
            if ((state == IDLE) && (req0 || req1)) begin
                owner <= winner;
                last  <= winner;
            end
            if (state == ACCESS) begin
                is_read <= ~sel_we;
                if (!sel_we) begin
                    rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural 256x8 memory
module tb_dmem_arbiter;

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } rd_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [0:255];

    gnt_t exp_gnt[$];
    rd_t  exp_rd[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

    wire [19:0] obs_bus = {gnt1, gnt0, mem_write, mem_read, mem_addr, mem_wdata};
    wire [9:0]  obs_rv  = {rvalid1, rvalid0, rdata};

    function automatic logic [19:0] exp_bus(gnt_t g);
        return {g.port, ~g.port, g.we, ~g.we, g.addr, g.wdata};
    endfunction

    function automatic logic [9:0] exp_rv(rd_t r);
        return {r.port, ~r.port, r.data};
    endfunction

    task automatic issue(input logic port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rexp);
        if (port == 1'b0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end
        exp_gnt.push_back({port, we, addr, wdata});
        if (!we) exp_rd.push_back({port, rexp});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({obs_bus, obs_rv} !== 30'h0) begin
            n_bad++; $display("FAIL reset_outputs: got bus=%h rv=%h want 0", obs_bus, obs_rv);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({obs_bus, obs_rv} !== 30'h0) begin
            n_bad++; $display("FAIL reset_release_idle: got bus=%h rv=%h want 0", obs_bus, obs_rv);
        end
    endtask

    task automatic test_write_read();
        gnt_t g;
        rd_t  r;
        issue(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
        @(negedge clk);
        g = exp_gnt.pop_front();
        n_cmp++;
        if (obs_bus !== exp_bus(g)) begin
            n_bad++; $display("FAIL p0_write_gnt: got %h want %h", obs_bus, exp_bus(g));
        end
        req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rvalid1, rvalid0} !== 2'b00) begin
            n_bad++; $display("FAIL p0_write_no_rvalid: got %b want 00", {rvalid1, rvalid0});
        end
        @(negedge clk);
        issue(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        @(negedge clk);
        g = exp_gnt.pop_front();
        n_cmp++;
        if (obs_bus !== exp_bus(g)) begin
            n_bad++; $display("FAIL p0_read_gnt: got %h want %h", obs_bus, exp_bus(g));
        end
        req0 = 1'b0;
        @(negedge clk);
        r = exp_rd.pop_front();
        n_cmp++;
        if (obs_rv !== exp_rv(r)) begin
            n_bad++; $display("FAIL p0_read_rvalid: got %h want %h", obs_rv, exp_rv(r));
        end
        @(negedge clk);
    endtask

    task automatic test_dma_write_cpu_read();
        gnt_t g;
        rd_t  r;
        issue(1'b1, 1'b1, 8'hFF, 8'h3C, 8'h00);
        @(negedge clk);
        g = exp_gnt.pop_front();
        n_cmp++;
        if (obs_bus !== exp_bus(g)) begin
            n_bad++; $display("FAIL p1_write_gnt: got %h want %h", obs_bus, exp_bus(g));
        end
        req1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rvalid1, rvalid0} !== 2'b00) begin
            n_bad++; $display("FAIL p1_write_no_rvalid: got %b want 00", {rvalid1, rvalid0});
        end
        @(negedge clk);
        issue(1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C);
        @(negedge clk);
        g = exp_gnt.pop_front();
        n_cmp++;
        if (obs_bus !== exp_bus(g)) begin
            n_bad++; $display("FAIL p0_read_ff_gnt: got %h want %h", obs_bus, exp_bus(g));
        end
        req0 = 1'b0;
        @(negedge clk);
        r = exp_rd.pop_front();
        n_cmp++;
        if (obs_rv !== exp_rv(r)) begin
            n_bad++; $display("FAIL p0_read_ff_rvalid: got %h want %h", obs_rv, exp_rv(r));
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        gnt_t g;
        rd_t  r;
        logic m_last;
        logic w;
        int   ngnt;
        int   last_cyc;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            w = ~m_last;
`else
            w = 1'b0;
`endif
            m_last = w;
            exp_gnt.push_back({w, 1'b0, (w ? 8'hFF : 8'h10), 8'h00});
            exp_rd.push_back({w, (w ? 8'h3C : 8'hA5)});
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; wdata0 = 8'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF; wdata1 = 8'h00;
        ngnt = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                n_cmp++;
                if (exp_gnt.size() == 0) begin
                    n_bad++; $display("FAIL arb_extra_gnt: got bus=%h want no grant", obs_bus);
                end else begin
                    g = exp_gnt.pop_front();
                    if (obs_bus !== exp_bus(g)) begin
                        n_bad++; $display("FAIL arb_gnt: got %h want %h", obs_bus, exp_bus(g));
                    end
                end
                if (last_cyc >= 0) begin
                    n_cmp++;
                    if (cyc - last_cyc != 3) begin
                        n_bad++; $display("FAIL arb_spacing: got %0d want 3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                ngnt++;
                if (ngnt == 4) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
            if (rvalid0 || rvalid1) begin
                n_cmp++;
                if (exp_rd.size() == 0) begin
                    n_bad++; $display("FAIL arb_extra_rvalid: got rv=%h want none", obs_rv);
                end else begin
                    r = exp_rd.pop_front();
                    if (obs_rv !== exp_rv(r)) begin
                        n_bad++; $display("FAIL arb_rvalid: got %h want %h", obs_rv, exp_rv(r));
                    end
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_cmp++;
        if (ngnt != 4) begin
            n_bad++; $display("FAIL arb_grant_count: got %0d want 4", ngnt);
        end
    endtask

    task automatic test_idle_hold();
        gnt_t g;
        rd_t  r;
        issue(1'b0, 1'b1, 8'h40, 8'h5A, 8'h00);
        @(negedge clk);
        g = exp_gnt.pop_front();
        n_cmp++;
        if (obs_bus !== exp_bus(g)) begin
            n_bad++; $display("FAIL hold_write_gnt: got %h want %h", obs_bus, exp_bus(g));
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        issue(1'b0, 1'b0, 8'h40, 8'h00, 8'h5A);
        @(negedge clk);
        g = exp_gnt.pop_front();
        n_cmp++;
        if (obs_bus !== exp_bus(g)) begin
            n_bad++; $display("FAIL hold_read_gnt: got %h want %h", obs_bus, exp_bus(g));
        end
        req0 = 1'b0;
        @(negedge clk);
        r = exp_rd.pop_front();
        n_cmp++;
        if (obs_rv !== exp_rv(r)) begin
            n_bad++; $display("FAIL hold_read_rvalid: got %h want %h", obs_rv, exp_rv(r));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write} !== 6'b0) begin
                n_bad++; $display("FAIL idle_quiet: cycle %0d got %b want 000000", i,
                                  {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write});
            end
            n_cmp++;
            if (rdata !== 8'h5A) begin
                n_bad++; $display("FAIL idle_rdata_hold: cycle %0d got %h want 5a", i, rdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        gnt_t g;
        rd_t  r;
        issue(1'b1, 1'b1, 8'h20, 8'h77, 8'h00);
        @(negedge clk);
        g = exp_gnt.pop_front();
        n_cmp++;
        if (obs_bus !== exp_bus(g)) begin
            n_bad++; $display("FAIL rst_access_gnt: got %h want %h", obs_bus, exp_bus(g));
        end
        reset = 1'b1;
        req1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({obs_bus, obs_rv} !== 30'h0) begin
            n_bad++; $display("FAIL rst_access_outputs: got bus=%h rv=%h want 0", obs_bus, obs_rv);
        end
        n_cmp++;
        if (mem[8'h20] !== 8'h77) begin
            n_bad++; $display("FAIL rst_access_commit: got %h want 77", mem[8'h20]);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({obs_bus, obs_rv} !== 30'h0) begin
                n_bad++; $display("FAIL rst_after_quiet: cycle %0d got bus=%h rv=%h want 0", i, obs_bus, obs_rv);
            end
        end
        issue(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        @(negedge clk);
        g = exp_gnt.pop_front();
        n_cmp++;
        if (obs_bus !== exp_bus(g)) begin
            n_bad++; $display("FAIL rst_resp_gnt: got %h want %h", obs_bus, exp_bus(g));
        end
        req0 = 1'b0;
        @(negedge clk);
        r = exp_rd.pop_front();
        n_cmp++;
        if (obs_rv !== exp_rv(r)) begin
            n_bad++; $display("FAIL rst_resp_rvalid: got %h want %h", obs_rv, exp_rv(r));
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({obs_bus, obs_rv} !== 30'h0) begin
            n_bad++; $display("FAIL rst_resp_suppress: got bus=%h rv=%h want 0", obs_bus, obs_rv);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dma_write_cpu_read();
        test_contention();
        test_idle_hold();
        test_reset_mid();
        n_cmp++;
        if (exp_gnt.size() + exp_rd.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_gnt.size() + exp_rd.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
